// File: rtl/tree_arb_pkg.sv
// Shared types and constants for the round-robin tree reduction arbiter.
package tree_arb_pkg;

    localparam int unsigned TREE_LATENCY = 3;
    // Wide enough for the largest supported requester count (8).
    localparam int unsigned TAG_ID_W     = 3;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalt
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/tree_arbiter_if.sv
// Request, reduction-unit and response signals of the tree arbiter.
interface tree_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*16-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [15:0]         tree_a;
    logic                tree_b;
    logic                resp_valid;
    logic [ID_W-1:0]     resp_id;
    logic                resp_data;
    logic                drain;
    logic                drained;
    logic                busy;

    modport slave (
        input  req_valid, req_data, tree_b, drain,
        output req_ready, tree_a, resp_valid, resp_id, resp_data, drained, busy
    );

    modport master (
        output req_valid, req_data, tree_b, drain,
        input  req_ready, tree_a, resp_valid, resp_id, resp_data, drained, busy
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin select: first valid requester at or after ptr, wrapping.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  id_o
);

    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        gnt_o = '0;
        id_o  = '0;
        sum   = '0;
        idx   = '0;
        // Walk from the farthest offset inward so the nearest valid requester is written last.
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (valid_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                id_o       = idx;
            end
        end
    end

endmodule

// File: rtl/tree_arbiter.sv
// Round-robin scheduler sharing one pipelined reduction unit, with tagged responses and drain.
// Optional per-requester saturating grant counters when TREE_ARB_PERF_EN is defined.
module tree_arbiter
    import tree_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LATENCY = TREE_LATENCY
) (
    input logic                 clk,
    input logic                 rst,
    tree_arbiter_if.slave       bus
`ifdef TREE_ARB_PERF_EN
    ,
    output logic [N_REQ*16-1:0] perf_grants
`endif
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    state_e           state_q;
    logic             drained_q;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] pick_oh, gnt;
    logic [ID_W-1:0]  pick_id;
    logic             gnt_en, gnt_any;
    tag_t             tag_q [LATENCY];
    logic             busy, upstream_busy;
    logic             unused_tag_id;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_oh),
        .id_o    (pick_id)
    );

    assign gnt_en  = (state_q == StRun) && !bus.drain;
    assign gnt     = gnt_en ? pick_oh : '0;
    assign gnt_any = |gnt;
    assign ptr_d   = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + 1'b1;

    always_comb begin
        bus.tree_a = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt[i]) bus.tree_a = bus.req_data[16*i +: 16];
        end
    end

    // Stages before the last decide whether anything is still on its way to the response port.
    always_comb begin
        upstream_busy = 1'b0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            upstream_busy = upstream_busy | tag_q[i].valid;
        end
        busy = upstream_busy | tag_q[LATENCY-1].valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) tag_q[i] <= '0;
        end else begin
            if (gnt_any) ptr_q <= ptr_d;
            tag_q[0] <= '{valid: gnt_any, id: TAG_ID_W'(pick_id)};
            for (int i = 1; i < int'(LATENCY); i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // HALT is entered as the last tag reaches the output, so drained never overlaps busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            drained_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.drain) state_q <= StDrain;
                end
                StDrain: begin
                    if (!upstream_busy) begin
                        state_q   <= StHalt;
                        drained_q <= 1'b1;
                    end
                end
                StHalt: begin
                    if (!bus.drain) begin
                        state_q   <= StRun;
                        drained_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StRun;
                    drained_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.resp_valid = tag_q[LATENCY-1].valid;
    assign bus.resp_id    = tag_q[LATENCY-1].id[ID_W-1:0];
    assign bus.resp_data  = bus.tree_b;
    assign bus.drained    = drained_q;
    assign bus.busy       = busy;
    assign unused_tag_id  = ^tag_q[LATENCY-1].id;

`ifdef TREE_ARB_PERF_EN
    logic [15:0] perf_q [N_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (rst) begin
                perf_q[i] <= '0;
            end else if (gnt[i] && (perf_q[i] != 16'hFFFF)) begin
                perf_q[i] <= perf_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        perf_grants = '0;
        for (int i = 0; i < int'(N_REQ); i++) perf_grants[16*i +: 16] = perf_q[i];
    end
`endif

endmodule

// File: tb/tb_tree_arbiter.sv
// Directed self-checking bench for tree_arbiter with a behavioural 3-cycle reduction unit.
module tb_tree_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic       u1, u2, u3;
    logic [3:0] exp_bits;
    logic [3:0] exp_oh;

    tree_arbiter_if #(.N_REQ(4)) bus ();

`ifdef TREE_ARB_PERF_EN
    logic [63:0] perf_grants;
`endif

    tree_arbiter #(
        .N_REQ   (4),
        .LATENCY (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef TREE_ARB_PERF_EN
        ,
        .perf_grants (perf_grants)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic fold(input logic [15:0] a);
        logic [7:0] l1;
        logic [3:0] l2;
        logic [1:0] l3;
        l1 = a[15:8] & a[7:0];
        l2 = l1[7:4] ^ l1[3:0];
        l3 = l2[3:2] | l2[1:0];
        return l3[1] ^ l3[0];
    endfunction

    always @(posedge clk) begin
        u1 <= fold(bus.tree_a);
        u2 <= u1;
        u3 <= u2;
    end
    assign bus.tree_b = u3;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.drain     = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_drained", 32'(bus.drained), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_tree_a", 32'(bus.tree_a), 0);

        // Single requester, operand folding to 1.
        cyc();
        bus.req_valid = 4'b0001;
        bus.req_data[15:0] = 16'h0101;
        #1;
        chk("t1_ready", 32'(bus.req_ready), 32'b0001);
        chk("t1_tree_a", 32'(bus.tree_a), 32'h0101);
        cyc();
        bus.req_valid = '0;
        #1;
        chk("t1_lat1", 32'(bus.resp_valid), 0);
        chk("t1_busy", 32'(bus.busy), 1);
        cyc();
        #1;
        chk("t1_lat2", 32'(bus.resp_valid), 0);
        cyc();
        #1;
        chk("t1_resp_valid", 32'(bus.resp_valid), 1);
        chk("t1_resp_id", 32'(bus.resp_id), 0);
        chk("t1_resp_data", 32'(bus.resp_data), 1);

        // Same requester, operand folding to 0.
        cyc();
        bus.req_valid = 4'b0001;
        bus.req_data[15:0] = 16'hFFFF;
        #1;
        chk("t1b_ready", 32'(bus.req_ready), 32'b0001);
        cyc();
        bus.req_valid = '0;
        cyc();
        cyc();
        #1;
        chk("t1b_resp_valid", 32'(bus.resp_valid), 1);
        chk("t1b_resp_data", 32'(bus.resp_data), 0);
        cyc();
        #1;
        chk("t1b_resp_gone", 32'(bus.resp_valid), 0);

        // Reset to ptr=0, then all four valid for 8 cycles.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_data = {16'h1010, 16'h0303, 16'hFFFF, 16'h0101};
        exp_bits = 4'b1001;
        for (int k = 0; k < 11; k++) begin
            cyc();
            bus.req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) begin
                exp_oh = 4'b0001 << (k % 4);
                chk("rr_grant", 32'(bus.req_ready), 32'(exp_oh));
            end
            if (k >= 3) begin
                chk("rr_resp_valid", 32'(bus.resp_valid), 1);
                chk("rr_resp_id", 32'(bus.resp_id), 32'((k - 3) % 4));
                chk("rr_resp_data", 32'(bus.resp_data), 32'(exp_bits[(k - 3) % 4]));
            end
        end

        // Wrap and skip: move ptr to 3, then 4'b0101.
        cyc();
        bus.req_valid = 4'b0100;
        #1;
        chk("ws_setup", 32'(bus.req_ready), 32'b0100);
        cyc();
        bus.req_valid = 4'b0101;
        #1;
        chk("ws_wrap", 32'(bus.req_ready), 32'b0001);
        cyc();
        #1;
        chk("ws_skip", 32'(bus.req_ready), 32'b0100);
        cyc();
        #1;
        chk("ws_ptr3", 32'(bus.req_ready), 32'b0001);
        cyc();
        bus.req_valid = '0;
        repeat (4) cyc();

        // Drain with two operands in flight.
        bus.req_valid = 4'b0011;
        #1;
        chk("dr_g0", 32'(bus.req_ready), 32'b0010);
        cyc();
        #1;
        chk("dr_g1", 32'(bus.req_ready), 32'b0001);
        cyc();
        bus.drain = 1'b1;
        #1;
        chk("dr_wins", 32'(bus.req_ready), 0);
        cyc();
        #1;
        chk("dr_nogrant", 32'(bus.req_ready), 0);
        chk("dr_resp0_valid", 32'(bus.resp_valid), 1);
        chk("dr_resp0_id", 32'(bus.resp_id), 1);
        chk("dr_not_drained0", 32'(bus.drained), 0);
        cyc();
        #1;
        chk("dr_resp1_valid", 32'(bus.resp_valid), 1);
        chk("dr_resp1_id", 32'(bus.resp_id), 0);
        chk("dr_not_drained1", 32'(bus.drained), 0);
        cyc();
        #1;
        chk("dr_drained", 32'(bus.drained), 1);
        chk("dr_busy", 32'(bus.busy), 0);
        chk("dr_resp_idle", 32'(bus.resp_valid), 0);
        cyc();
        bus.drain = 1'b0;
        #1;
        chk("dr_halt_hold", 32'(bus.drained), 1);
        chk("dr_halt_nogrant", 32'(bus.req_ready), 0);
        cyc();
        #1;
        chk("dr_run_drained", 32'(bus.drained), 0);
        chk("dr_run_grant", 32'(bus.req_ready), 32'b0010);
        cyc();
        bus.req_valid = '0;
        repeat (4) cyc();

        // Reset mid-operation discards in-flight tags.
        bus.req_valid = 4'hF;
        repeat (3) cyc();
        rst = 1'b1;
        bus.req_valid = '0;
        cyc();
        rst = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        chk("mr_ptr0", 32'(bus.req_ready), 32'b0001);
        chk("mr_busy", 32'(bus.busy), 0);
        chk("mr_resp0", 32'(bus.resp_valid), 0);
        cyc();
        bus.req_valid = '0;
        #1;
        chk("mr_resp1", 32'(bus.resp_valid), 0);
        cyc();
        #1;
        chk("mr_resp2", 32'(bus.resp_valid), 0);
        cyc();
        #1;
        chk("mr_new_valid", 32'(bus.resp_valid), 1);
        chk("mr_new_id", 32'(bus.resp_id), 0);
        repeat (3) cyc();

`ifdef TREE_ARB_PERF_EN
        // Saturating counter for requester 1.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_valid = 4'b0010;
        repeat (70000) cyc();
        bus.req_valid = '0;
        #1;
        chk("perf_r1_sat", 32'(perf_grants[31:16]), 32'hFFFF);
        chk("perf_r0", 32'(perf_grants[15:0]), 0);
        chk("perf_r2", 32'(perf_grants[47:32]), 0);
        chk("perf_r3", 32'(perf_grants[63:48]), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tree_arbiter.md
Name: tree_arbiter

Overview:
- Round-robin scheduler that shares one 16-bit AND/XOR/OR/XOR pipelined reduction unit (`tree_a` in, `tree_b` out, fixed 3-cycle latency, no reset, no stall) among N_REQ requesters.
- Issues at most one operand per cycle and tracks requester IDs through a tag shift register aligned to the unit latency, so each result is returned tagged with its requester.
- Provides a drain handshake so upstream control can quiesce the unit before reconfiguration or flush.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LATENCY, 3, cycles from `tree_a` presented to `tree_b` valid; must match the reduction unit.
- ID_W, $clog2(N_REQ), requester ID width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_data  in  N_REQ*16  operands; requester i occupies bits [16*i+15:16*i].
- req_ready  out  N_REQ  one-hot grant; the transfer happens when valid & ready.
- tree_a  out  16  operand to the reduction unit.
- tree_b  in  1  result from the reduction unit.
- resp_valid  out  1  result valid this cycle.
- resp_id  out  ID_W  requester owning the result.
- resp_data  out  1  result bit, equal to `tree_b`.
- drain  in  1  request to stop issuing and empty the pipeline.
- drained  out  1  high in HALT: no grants and nothing in flight.
- busy  out  1  at least one tag in flight.

Behaviour:
- Reset (synchronous, active-high) values: state=RUN, ptr=0, all tag-valid stages=0, resp_valid=0, resp_id=0, drained=0, busy=0. `tree_b` is ignored while no tag is valid; the unit's stale contents are harmless.
- Grant (combinational):
  - Enabled only when state==RUN && !drain.
  - Winner is the first i with req_valid[i], scanning ptr, ptr+1, ... mod N_REQ.
  - req_ready = one-hot(winner), or 0 when no valid requester or grant is disabled.
  - req_ready may depend on req_valid. Requesters must hold valid/data stable until ready.
- On a grant to i: `ptr` <= (i+1) mod N_REQ, with wrap from N_REQ-1 to 0. With no grant, `ptr` holds.
- tree_a = req_data of the winner, or 16'h0000 when there is no grant.
- Tag pipe: LATENCY stages of {valid, id}. Stage 0 loads {grant_any, winner_id} each cycle. The last stage drives resp_valid/resp_id.
  - An operand granted in cycle t produces resp_valid=1, resp_id=i, resp_data=tree_b in cycle t+LATENCY.
  - No backpressure on the response; the consumer must accept every cycle.
- Throughput: one issue per cycle. Back-to-back grants yield back-to-back responses in grant order.
- busy = OR of all tag-valid stages.
- FSM:
  - RUN: drain=1 -> DRAIN (no grant in the cycle drain rises).
  - DRAIN: no grants; when busy==0 -> HALT. Deasserting drain does not abort DRAIN.
  - HALT: drained=1, no grants; drain==0 -> RUN.
- Drain on an idle pipe: drain rises in cycle t, state is DRAIN in t+1, HALT in t+2, drained=1 from t+2.
- Reset mid-operation: all in-flight tags are discarded. No resp_valid appears for operands issued before reset.
- Simultaneous drain and a requester valid in RUN: drain wins and no grant occurs.

Optional Feature:
- Macro: TREE_ARB_PERF_EN.
- Defined:
  - Adds output perf_grants (N_REQ*16): one 16-bit saturating grant counter per requester.
  - Counters reset to 0 on rst, increment on each grant, and hold at 16'hFFFF.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package tree_arb_pkg holds the state enum (RUN, DRAIN, HALT), typedef tag_t {logic valid; logic [ID_W-1:0] id}, and the constant TREE_LATENCY=3.
- One sub-module, rr_picker: combinational round-robin priority select with inputs valid vector and ptr, outputs one-hot grant and encoded id.
- The reduction unit is instantiated outside this block, next to it.

Test Plan:
- Single requester: req_valid=4'b0001, req_data[15:0]=16'h0101 in cycle 5 -> req_ready=4'b0001 in cycle 5; cycle 8 resp_valid=1, resp_id=0, resp_data=1. Repeat with 16'hFFFF -> resp_data=0.
- All four valid, held for 8 cycles from ptr=0 -> grant order 0,1,2,3,0,1,2,3; responses in the same id order 3 cycles later, one per cycle.
- Wrap and skip: ptr=3, req_valid=4'b0101 -> grant 0, ptr=1; next cycle grant 2, ptr=3.
- Drain with 2 in flight (grants in cycles 10 and 11, drain=1 in cycle 12) -> no grants from cycle 12, responses in cycles 13 and 14, HALT and drained=1 in cycle 15; drain=0 in cycle 16 -> RUN in cycle 17 and grants resume.
- Reset mid-operation: grants in cycles 20–22, rst=1 in cycle 23 -> resp_valid=0 in cycles 24–26, ptr=0, busy=0.
- With TREE_ARB_PERF_EN defined: 70000 grants to requester 1 -> perf_grants[31:16]=16'hFFFF and all other counters 0.
